// File: rtl/pool_pkg.sv
// Shared constants and width helpers for the streaming pooling engine.
package pool_pkg;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } pool_mode_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // A full window sum of POOL*POOL pixels needs 2*log2(POOL) guard bits.
    function automatic int acc_w(input int data_w, input int pool);
        return data_w + 2 * clog2(pool);
    endfunction

endpackage

// File: rtl/pool2d_stream_if.sv
// Pixel-in / pooled-value-out stream bundle for pool2d_stream.
interface pool2d_stream_if #(
    parameter int DATA_W = 8
);
    logic                     mode;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pool_linebuf.sv
// Per-window-column partial result store: sync write, combinational read.
module pool_linebuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Every entry is written at ky = 0 before it is read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pool2d_stream.sv
// Streaming non-overlapping POOL x POOL max/average pooling over a raster-order
// feature map, with a single-entry output register and valid/ready on both sides.
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int POOL   = 2,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input logic            clk,
    input logic            rst_n,
    pool2d_stream_if.slave s
);
    localparam int LOG2P = clog2(POOL);
    localparam int SH    = 2 * LOG2P;
    localparam int ACC_W = acc_w(DATA_W, POOL);
    localparam int COL_W = clog2(IMG_W);
    localparam int ROW_W = clog2(IMG_H);
    localparam int LB_D  = IMG_W / POOL;
    localparam int LB_AW = (LB_D > 1) ? clog2(LB_D) : 1;

    typedef logic signed [ACC_W-1:0] acc_t;

    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic [LOG2P-1:0]         kx, ky;
    logic [LB_AW-1:0]         wx;
    pool_mode_e               mode_q, cur_mode;
    acc_t                     h_acc, px, v, lb_rd, lv, lb_wd;
    logic                     accept, first, kx_last, ky_first, ky_last;
    logic                     col_last, row_last, done, lb_we;
    logic signed [DATA_W-1:0] res;
    logic                     ov_q, ol_q;
    logic signed [DATA_W-1:0] od_q;

    function automatic acc_t combine(input pool_mode_e m, input acc_t a, input acc_t b);
        if (m == MODE_AVG) return a + b;
        return (a > b) ? a : b;
    endfunction

    // Never stall mid-window: a new result can always replace a popped one.
    assign s.in_ready = !ov_q || s.out_ready;
    assign accept     = s.in_valid && s.in_ready;

    assign kx       = col[LOG2P-1:0];
    assign ky       = row[LOG2P-1:0];
    assign wx       = LB_AW'(col >> LOG2P);
    assign kx_last  = &kx;
    assign ky_first = (ky == '0);
    assign ky_last  = &ky;
    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));
    assign first    = (col == '0) && (row == '0);

    // The first pixel of a frame uses the live mode; the rest use the latched one.
    assign cur_mode = first ? pool_mode_e'(s.mode) : mode_q;

    assign px    = {{(ACC_W - DATA_W){s.in_data[DATA_W-1]}}, s.in_data};
    assign v     = combine(cur_mode, h_acc, px);
    assign lv    = combine(cur_mode, lb_rd, v);
    assign lb_we = accept && kx_last && !ky_last;
    assign lb_wd = ky_first ? v : lv;
    assign done  = accept && kx_last && ky_last;
    assign res   = (cur_mode == MODE_AVG) ? DATA_W'(lv >>> SH) : DATA_W'(lv);

    pool_linebuf #(
        .DEPTH (LB_D),
        .WIDTH (ACC_W),
        .AW    (LB_AW)
    ) u_linebuf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (wx),
        .wdata (lb_wd),
        .raddr (wx),
        .rdata (lb_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            h_acc  <= '0;
            mode_q <= MODE_MAX;
        end else if (accept) begin
            h_acc <= (kx == '0) ? px : v;
            if (first) mode_q <= pool_mode_e'(s.mode);
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // A completing window has priority; it also covers the pop-and-load case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
            od_q <= '0;
            ol_q <= 1'b0;
        end else if (done) begin
            ov_q <= 1'b1;
            od_q <= res;
            ol_q <= row_last && col_last;
        end else if (s.out_ready) begin
            ov_q <= 1'b0;
        end
    end

    assign s.out_valid = ov_q;
    assign s.out_data  = od_q;
    assign s.out_last  = ol_q;
endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: a 4x4/POOL=2 instance and an 8x8/POOL=4 instance
// checked against a window-by-window arithmetic reference.
module tb_pool2d_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_d[$];
    bit   exp_l[$];
    int   pop_cyc[$];
    int   fr[$];

    always #5 clk = ~clk;

    pool2d_stream_if #(.DATA_W(8)) ifa ();
    pool2d_stream_if #(.DATA_W(8)) ifb ();

    pool2d_stream #(.DATA_W(8), .POOL(2), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(ifa.slave));
    pool2d_stream #(.DATA_W(8), .POOL(4), .IMG_W(8), .IMG_H(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(ifb.slave));

    // Reference: every window from the frame, max or floor(sum / POOL^2).
    task automatic model(input int pix[$], input int w, input int p, input bit m);
        int h, n, s, mx, val, q;
        h = pix.size() / w;
        n = p * p;
        exp_d.delete();
        exp_l.delete();
        for (int wy = 0; wy < h / p; wy++) begin
            for (int wxi = 0; wxi < w / p; wxi++) begin
                s  = 0;
                mx = -100000;
                for (int dy = 0; dy < p; dy++) begin
                    for (int dx = 0; dx < p; dx++) begin
                        val = pix[(wy * p + dy) * w + wxi * p + dx];
                        s += val;
                        if (val > mx) mx = val;
                    end
                end
                q = s / n;
                if ((s % n != 0) && (s < 0)) q = q - 1;
                exp_d.push_back(m ? q : mx);
                exp_l.push_back((wy == h / p - 1) && (wxi == w / p - 1));
            end
        end
    endtask

    task automatic rand_frame(input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(int'($urandom_range(255)) - 128);
    endtask

    task automatic drv(input int which, input bit v, input int d, input bit m, input bit r);
        if (which == 0) begin
            ifa.in_valid = v; ifa.in_data = 8'(d); ifa.mode = m; ifa.out_ready = r;
        end else begin
            ifb.in_valid = v; ifb.in_data = 8'(d); ifb.mode = m; ifb.out_ready = r;
        end
    endtask

    task automatic smp(input int which, output bit iv, output bit ir, output bit ov,
                       output bit orr, output int od, output bit ol);
        if (which == 0) begin
            iv = ifa.in_valid; ir = ifa.in_ready; ov = ifa.out_valid;
            orr = ifa.out_ready; od = int'(ifa.out_data); ol = ifa.out_last;
        end else begin
            iv = ifb.in_valid; ir = ifb.in_ready; ov = ifb.out_valid;
            orr = ifb.out_ready; od = int'(ifb.out_data); ol = ifb.out_last;
        end
    endtask

    // Streams one frame, popping and checking results as they appear.
    task automatic run(input int which, input int pix[$], input bit m, input int flip_at,
                       input int vpct, input int rpct, input int stall_n, input string name);
        int w, p, idx, got, cyc, stall, od;
        bit iv, ir, ov, orr, ol, md, rdy, vld;
        w = (which == 0) ? 4 : 8;
        p = (which == 0) ? 2 : 4;
        idx = 0; got = 0; cyc = 0; stall = 0; md = m;
        model(pix, w, p, m);
        pop_cyc.delete();
        while (got < exp_d.size() && cyc < 3000) begin
            md  = (flip_at >= 0 && idx >= flip_at) ? !m : m;
            rdy = (got == 0 && stall < stall_n) ? 1'b0 : ($urandom_range(99) < rpct);
            vld = (idx < pix.size()) && ($urandom_range(99) < vpct);
            drv(which, vld, (idx < pix.size()) ? pix[idx] : 0, md, rdy);
            @(negedge clk);
            smp(which, iv, ir, ov, orr, od, ol);
            if (ov && !orr && got == 0 && stall_n > 0) begin
                checks++;
                if (ir !== 1'b0 || od !== exp_d[0]) begin
                    errors++;
                    $display("FAIL %s_hold: in_ready=%0b data=%0d, expected in_ready=0 data=%0d",
                             name, ir, od, exp_d[0]);
                end
                stall++;
            end
            if (iv && ir) idx++;
            if (ov && orr) begin
                checks++;
                if (od !== exp_d[got] || ol !== exp_l[got]) begin
                    errors++;
                    $display("FAIL %s_out[%0d]: data=%0d last=%0b, expected data=%0d last=%0b",
                             name, got, od, ol, exp_d[got], exp_l[got]);
                end
                pop_cyc.push_back(cyc);
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        drv(which, 1'b0, 0, md, 1'b1);
        checks++;
        if (got != exp_d.size() || idx != pix.size()) begin
            errors++;
            $display("FAIL %s_count: results=%0d pixels=%0d, expected results=%0d pixels=%0d",
                     name, got, idx, exp_d.size(), pix.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drv(0, 1'b0, 0, 1'b0, 1'b1);
        drv(1, 1'b0, 0, 1'b0, 1'b1);
        #2;
        checks++;
        if (ifa.out_valid !== 1'b0 || ifa.out_data !== 8'sd0 || ifa.out_last !== 1'b0 ||
            ifb.out_valid !== 1'b0 || ifb.out_data !== 8'sd0 || ifb.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: a=%0b/%0d/%0b b=%0b/%0d/%0b, expected all 0",
                     ifa.out_valid, ifa.out_data, ifa.out_last,
                     ifb.out_valid, ifb.out_data, ifb.out_last);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: a=%0b b=%0b, expected 1", ifa.in_ready, ifb.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max_frame;
        int f[$];
        int want[$];
        f = {1, 5, 2, 0, 3, 4, 9, 8, -7, -1, 6, 6, -2, -8, 6, 7};
        want = {6, 8, 14, 16};
        run(0, f, 1'b0, -1, 100, 100, 0, "max4x4");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= pop_cyc.size() || pop_cyc[i] != want[i]) begin
                errors++;
                $display("FAIL max4x4_timing[%0d]: cycle=%0d, expected %0d", i,
                         (i < pop_cyc.size()) ? pop_cyc[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_avg_frame;
        int f[$];
        f = {1, 5, 2, 0, 3, 4, 9, 8, -7, -1, 6, 6, -2, -8, 6, 7};
        run(0, f, 1'b1, -1, 100, 100, 0, "avg4x4");
    endtask

    task automatic test_extremes;
        int lo[$], hi[$];
        for (int i = 0; i < 16; i++) begin lo.push_back(-128); hi.push_back(127); end
        run(0, lo, 1'b1, -1, 100, 100, 0, "avg_min");
        run(0, hi, 1'b1, -1, 100, 100, 0, "avg_max");
        run(0, lo, 1'b0, -1, 100, 100, 0, "max_min");
    endtask

    task automatic test_backpressure;
        int f[$];
        f = {1, 5, 2, 0, 3, 4, 9, 8, -7, -1, 6, 6, -2, -8, 6, 7};
        run(0, f, 1'b0, -1, 100, 100, 5, "stall");
        for (int k = 0; k < 3; k++) begin
            rand_frame(16);
            run(0, fr, k[0], -1, 70, 40, 3, "rand_bp");
        end
    endtask

    task automatic test_mode_change;
        rand_frame(16);
        run(0, fr, 1'b0, 5, 100, 100, 0, "mode_flip");
        rand_frame(16);
        run(0, fr, 1'b1, -1, 100, 100, 0, "mode_next");
    endtask

    task automatic test_reset_mid_frame;
        for (int i = 0; i < 6; i++) begin
            drv(0, 1'b1, 50 + i, 1'b1, 1'b0);
            @(posedge clk); #1;
        end
        drv(0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (ifa.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: out_valid=%0b, expected 1", ifa.out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifa.out_valid !== 1'b0 || ifa.out_data !== 8'sd0 || ifa.out_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: %0b/%0d/%0b, expected 0/0/0",
                     ifa.out_valid, ifa.out_data, ifa.out_last);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rand_frame(16);
        run(0, fr, 1'b0, -1, 100, 100, 0, "midrst_frame");
    endtask

    task automatic test_pool4;
        int ramp[$];
        for (int i = 0; i < 64; i++) ramp.push_back(i);
        run(1, ramp, 1'b0, -1, 100, 100, 0, "p4_ramp");
        rand_frame(64);
        run(1, fr, 1'b1, -1, 80, 50, 4, "p4_avg");
        rand_frame(64);
        run(1, fr, 1'b0, 20, 90, 60, 0, "p4_max");
    endtask

    task automatic test_random;
        for (int k = 0; k < 6; k++) begin
            rand_frame(16);
            run(0, fr, 1'($urandom_range(1)), -1, 60 + 8 * k, 100 - 10 * k, 0, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_max_frame();
        test_avg_frame();
        test_extremes();
        test_backpressure();
        test_mode_change();
        test_reset_mid_frame();
        test_pool4();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
- Streaming 2-D pooling engine; successor to the fixed 2x2 max-pool cell.
- Consumes one feature-map pixel per accepted beat in raster order. Emits one pooled value per non-overlapping POOL x POOL window (stride = POOL).
- Supports max or average mode, signed data, and valid/ready flow control on both sides.
- Sits between the convolution output stream and the next layer's input buffer.

Parameters:
- DATA_W, 8, signed pixel width.
- POOL, 2, window edge and stride; power of two, 2..8.
- IMG_W, 8, feature-map width in pixels; multiple of POOL.
- IMG_H, 8, feature-map height in pixels; multiple of POOL.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = max, 1 = average; sampled only on the first pixel of a frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DATA_W  signed pixel.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  signed pooled value.
- out_last  out  1  marks the final pooled value of a frame.

Behaviour:
- Reset (async, rst_n low) clears all outputs and state:
  - out_valid = 0, out_data = 0, out_last = 0.
  - in_ready = 1 after reset release.
  - Counters and partial results cleared; the line buffer needs no clearing.
  - A reset mid-frame discards the partial frame; the next accepted pixel is row 0, col 0.
- Counters advance only on an accepted beat:
  - col: 0..IMG_W-1, wraps to 0 and increments row.
  - row: 0..IMG_H-1, wraps to 0 at end of frame.
  - kx = col mod POOL, ky = row mod POOL, wx = col / POOL.
- Horizontal accumulator h_acc:
  - Loads in_data when kx = 0.
  - Otherwise combines: max(h_acc, in_data) in max mode; h_acc + in_data in average mode.
- Line buffer, at kx = POOL-1:
  - Combined value v = combine(h_acc, in_data).
  - ky = 0: write v to linebuf[wx].
  - 0 < ky < POOL-1: write combine(linebuf[wx], v).
  - ky = POOL-1: the result is combine(linebuf[wx], v) and is sent to the output register; no write.
- Arithmetic:
  - ACC_W = DATA_W + 2*log2(POOL). All sums are signed and sign-extended.
  - Max compare is signed.
  - Average result = ACC arithmetically shifted right by 2*log2(POOL) (floor toward minus infinity), then truncated to DATA_W. Truncation cannot overflow.
  - In max mode, values stay DATA_W wide inside ACC_W.
- Output register (single entry):
  - out_valid rises the cycle after the accepted pixel that completes a window.
  - out_data and out_last are held stable while out_valid & !out_ready.
  - out_last = 1 for the window completed by pixel (IMG_H-1, IMG_W-1).
- Flow control:
  - in_ready = !out_valid | out_ready, applied unconditionally so the pipeline never stalls mid-window.
  - Simultaneous output pop and new window completion in the same cycle loads the new result with no bubble.
  - Throughput is one pixel per cycle when out_ready is held high.
- Mode:
  - Latched at row 0, col 0 acceptance and held for the whole frame.
  - Changes to mode mid-frame are ignored.
- Line buffer depth is IMG_W/POOL entries of ACC_W bits. Read and write use the same wx within one cycle; a read-before-write register array is used.

Decomposition:
- Package pool_pkg: MODE_MAX = 1'b0, MODE_AVG = 1'b1; localparam function clog2; ACC_W derivation.
- Sub-module pool_linebuf:
  - Parametrised DEPTH x WIDTH register array.
  - One synchronous-write port and one combinational-read port.
  - Asynchronous clear not required.
- Top pool2d_stream contains the counters, h_acc, combine logic and the output register.

Test Plan:
- Max, POOL=2, 4x4 frame, rows {1,5,2,0},{3,4,9,8},{-7,-1,6,6},{-2,-8,6,7}, out_ready=1 -> out_data 5,9,-1,7; out_last only on 7; one result per 2 cycles in the second row of each pool band.
- Average, same frame -> 3 (13>>2), 4 (19>>2), -5 (-18>>2, floor), 6 (25>>2). Also DATA_W=8 all -128 -> -128, all 127 -> 127, no overflow.
- Backpressure: hold out_ready=0 after the first result -> out_valid stays 1, out_data stable, in_ready=0, no pixel lost. Release -> stream resumes, results match the no-stall run bit-exactly.
- Mode change mid-frame: start in max, flip mode to 1 at pixel 5 -> the whole frame stays max. Next frame uses average.
- Reset mid-frame: assert rst_n=0 after 6 pixels -> outputs 0 immediately (async). A fresh full frame after release produces the correct results, with no leakage from the stale line buffer.
- POOL=4, IMG_W=IMG_H=8, ramp in_data = row*8+col, max mode -> outputs 27,31,59,63; out_last on 63.
